fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter IM_WORDS, default 4096, instruction memory depth in 32-bit words; IM base is RESET_PC.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 stall  input  1  hazard hold from the hazard unit; 1 = freeze PC and suppress the D-stage load.
REQ-006 npcMode  input  3  next-PC select from the D-stage controller: 0 seq, 1 branch, 2 j/jal, 3 jr, 4-7 treated as seq.
REQ-007 cmpResult  input  1  D-stage comparator result; the branch is taken when 1.
REQ-008 PC_D  input  32  PC of the instruction currently in D.
REQ-009 imm26_D  input  26  instr_D[25:0]; bits [15:0] are the branch offset.
REQ-010 rsData_D  input  32  forwarded rs value for jr.
REQ-011 im_addr  output  12  IM word index, (PC_F-RESET_PC)[13:2].
REQ-012 im_data  input  32  combinational IM read data.
REQ-013 instr_F, PC_F  output  32 each  fetched instruction and its PC, to the D register.
REQ-014 squash_F  output  1  1 = D loads NOP instead of instr_F.
REQ-015 excAdEL_F  output  1  fetch address error flag.
REQ-016 fetchCount  output  32  count of valid instructions delivered.

Function
REQ-017 The NPC SHALL be PC_F+4 for seq, PC_D+4+(sext(imm16)<<2) for branch with cmpResult=1, PC_F+4 for branch with cmpResult=0, {PC_D[31:28],imm26_D,2'b00} for j/jal, and rsData_D for jr.
REQ-018 The redirect SHALL be the set {branch taken, j/jal, jr}.
REQ-019 All arithmetic SHALL be 32-bit modulo 2^32; PC_F+4 wraps silently.
REQ-020 The FSM states SHALL be BOOT, RUN and HALT.
REQ-021 The first edge after reset deassertion SHALL move the FSM from BOOT to RUN without a PC update; squash_F=1 in BOOT.
REQ-022 In RUN with stall=0, PC_F SHALL take the NPC; with stall=1, PC_F, the FSM state and fetchCount SHALL hold.
REQ-023 Stall and redirect asserted in the same cycle SHALL resolve in favour of stall; the redirect is re-evaluated on the next cycle from the held D values.
REQ-024 A PC_F that is misaligned (bits[1:0]!=0) or outside [RESET_PC, RESET_PC+4*IM_WORDS) SHALL produce combinationally instr_F=0, excAdEL_F=1 and squash_F=1.
REQ-025 On a non-stalled edge in RUN where the current PC_F is invalid, the FSM SHALL enter HALT.
REQ-026 In HALT, PC_F SHALL freeze, squash_F=1 and excAdEL_F=1, and only reset SHALL exit HALT.
REQ-027 fetchCount SHALL increment on every non-stalled RUN edge with a valid PC_F and squash_F=0, saturating at 32'hFFFF_FFFF.
REQ-028 instr_F SHALL otherwise equal im_data with zero latency (combinational IM).

Reset
REQ-029 While reset=0, the block SHALL set PC_F=RESET_PC, FSM=BOOT, fetchCount=0, squash_F=1 and excAdEL_F=0, independent of clk.
REQ-030 Reset asserted mid-redirect or mid-stall SHALL discard all pending state.

Configuration
REQ-031 With F_DELAY_SLOT_EN defined, the instruction fetched in the cycle a redirect resolves SHALL pass to D as a delay slot (squash_F=0).
REQ-032 With F_DELAY_SLOT_EN undefined, a non-stalled redirect SHALL assert squash_F=1 for that cycle and that slot SHALL not count in fetchCount.

Structure
REQ-033 The npcMode encodings, the NOP constant and the default RESET_PC SHALL reside in the shared param.v include.
REQ-034 The next-PC computation SHALL be a combinational sub-module npc_calc; the PC register, FSM and counter SHALL live in fetch_stage.

Verification
REQ-035 Reset release, stall=0, npcMode=0 -> PC_F 0x3000 (BOOT, squash_F=1), then 0x3000 (RUN), 0x3004, 0x3008; fetchCount 0,0,1,2.
REQ-036 PC_D=0x3010, imm16=0xFFFE, npcMode=1, cmpResult=1 -> next PC_F=0x300C; with cmpResult=0 -> PC_F+4.
REQ-037 npcMode=3, rsData_D=0x3002 -> PC_F=0x3002, excAdEL_F=1, next edge enters HALT; PC_F frozen until reset.
REQ-038 stall=1 for 3 cycles during jr to 0x3100 -> PC_F and fetchCount unchanged for 3 cycles, then PC_F=0x3100.
REQ-039 j with imm26=0x0000C40 -> PC_F=0x0000_3100; squash_F=1 without F_DELAY_SLOT_EN, 0 with it.
REQ-040 reset pulsed low asynchronously mid-cycle during a branch -> PC_F=0x3000 immediately, fetchCount=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select encodings, NOP word,
// default boot PC and the fetch FSM state type.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // npcMode encodings driven by the D-stage controller; 4-7 fall back to sequential.
    localparam logic [2:0] NPC_SEQ    = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, the D-stage controller/hazard unit and
// the instruction memory. master = fetch stage, slave = its environment.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    // Inputs to fetch: hazard hold, D-stage redirect info, IM read data.
    logic         stall;
    logic [2:0]   npcMode;
    logic         cmpResult;
    logic [31:0]  PC_D;
    logic [25:0]  imm26_D;
    logic [31:0]  rsData_D;
    logic [31:0]  im_data;

    // Outputs of fetch: IM word index, F->D payload, status and debug state.
    logic [11:0]  im_addr;
    logic [31:0]  instr_F;
    logic [31:0]  PC_F;
    logic         squash_F;
    logic         excAdEL_F;
    logic [31:0]  fetchCount;
    fetch_state_e state;

    modport master (
        input  stall, npcMode, cmpResult, PC_D, imm26_D, rsData_D, im_data,
        output im_addr, instr_F, PC_F, squash_F, excAdEL_F, fetchCount, state
    );

    modport slave (
        output stall, npcMode, cmpResult, PC_D, imm26_D, rsData_D, im_data,
        input  im_addr, instr_F, PC_F, squash_F, excAdEL_F, fetchCount, state
    );

endinterface

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection: sequential, taken branch, j/jal and jr,
// plus the redirect flag telling fetch the sequential slot is being abandoned.
module npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [2:0]  npc_mode,
    input  logic        cmp_result,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] npc,
    output logic        redirect
);

    logic [31:0] pc_f_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // All sums are plain 32-bit adds, so wrap-around is silent by construction.
    assign pc_f_plus4    = pc_f + 32'd4;
    assign branch_target = pc_d + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign jump_target   = {pc_d[31:28], imm26, 2'b00};

    always_comb begin
        npc      = pc_f_plus4;
        redirect = 1'b0;
        case (npc_mode)
            NPC_SEQ: begin
                npc      = pc_f_plus4;
                redirect = 1'b0;
            end
            NPC_BRANCH: begin
                if (cmp_result) begin
                    npc      = branch_target;
                    redirect = 1'b1;
                end
            end
            NPC_JUMP: begin
                npc      = jump_target;
                redirect = 1'b1;
            end
            NPC_JR: begin
                npc      = rs_data;
                redirect = 1'b1;
            end
            default: begin
                npc      = pc_f_plus4;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, BOOT/RUN/HALT FSM, delivered-instruction counter
// and fetch address checking. Optional macro F_DELAY_SLOT_EN keeps the slot behind a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) * 33'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q;
    logic [31:0]  pc_offset;
    logic [31:0]  npc;
    logic         redirect;
    logic         redirect_squash;
    logic         pc_valid;
    logic         squash;
    logic         count_en;

    npc_calc u_npc_calc (
        .npc_mode   (bus.npcMode),
        .cmp_result (bus.cmpResult),
        .pc_f       (pc_q),
        .pc_d       (bus.PC_D),
        .imm26      (bus.imm26_D),
        .rs_data    (bus.rsData_D),
        .npc        (npc),
        .redirect   (redirect)
    );

    // Offset is widened so a huge IM_WORDS cannot overflow the range compare.
    assign pc_offset = pc_q - RESET_PC;
    assign pc_valid  = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC)
                     && ({1'b0, pc_offset} < IM_BYTES);

`ifdef F_DELAY_SLOT_EN
    assign redirect_squash = 1'b0;
`else
    assign redirect_squash = redirect && !bus.stall;
`endif

    assign squash = (state_q != ST_RUN) || !pc_valid || redirect_squash;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_en = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.stall) begin
                    if (!pc_valid) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d     = npc;
                        count_en = !squash;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (count_en && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    assign bus.im_addr    = pc_offset[13:2];
    assign bus.instr_F    = pc_valid ? bus.im_data : NOP;
    assign bus.PC_F       = pc_q;
    assign bus.squash_F   = squash;
    assign bus.excAdEL_F  = (state_q == ST_HALT) || !pc_valid;
    assign bus.fetchCount = fetch_count_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push expected F outputs,
// a monitor pops and compares them on every falling clock or reset edge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

`ifdef F_DELAY_SLOT_EN
    localparam int DS = 1;
`else
    localparam int DS = 0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [31:0] instr;
        logic [11:0] addr;
        logic        sq;
        logic        exc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_3000),
        .IM_WORDS (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: each word holds a tag plus its own index.
    assign bus.im_data = {20'hACE00, bus.im_addr};

    task automatic set_in(input logic st, input logic [2:0] mode, input logic cmp,
                          input logic [31:0] pcd, input logic [25:0] imm,
                          input logic [31:0] rs);
        bus.stall     = st;
        bus.npcMode   = mode;
        bus.cmpResult = cmp;
        bus.PC_D      = pcd;
        bus.imm26_D   = imm;
        bus.rsData_D  = rs;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] pc,
                            input logic [31:0] cnt, input logic sq, input logic exc);
        exp_t        e;
        logic [31:0] off;
        logic        ok;
        off     = pc - 32'h0000_3000;
        ok      = (pc[1:0] == 2'b00) && (pc >= 32'h0000_3000) && (pc < 32'h0000_7000);
        e.pc    = pc;
        e.cnt   = cnt;
        e.addr  = off[13:2];
        e.instr = ok ? {20'hACE00, off[13:2]} : 32'h0;
        e.sq    = sq;
        e.exc   = exc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cyc(input string tag, input logic st, input logic [2:0] mode,
                       input logic cmp, input logic [31:0] pcd, input logic [25:0] imm,
                       input logic [31:0] rs, input logic [31:0] pc,
                       input logic [31:0] cnt, input logic sq, input logic exc);
        set_in(st, mode, cmp, pcd, imm, rs);
        push_exp(tag, pc, cnt, sq, exc);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous pulse away from the clock edge; returns just after a
    // rising edge with the FSM sitting in BOOT.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        push_exp({tag, "_async"}, 32'h3000, 0, 1'b1, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_exp({tag, "_held"}, 32'h3000, 0, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compares the oldest expectation against what the DUT shows now.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, ".pc"},    bus.PC_F,              e.pc);
                check({t, ".cnt"},   bus.fetchCount,        e.cnt);
                check({t, ".instr"}, bus.instr_F,           e.instr);
                check({t, ".addr"},  32'(bus.im_addr),      32'(e.addr));
                check({t, ".sq"},    32'(bus.squash_F),     32'(e.sq));
                check({t, ".exc"},   32'(bus.excAdEL_F),    32'(e.exc));
            end
        end
    end

    initial begin
        set_in(1'b0, NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0);
        #1;
        push_exp("rst_init", 32'h3000, 0, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Boot and sequential fetch.
        cyc("boot", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3000, 0, 1, 0);
        cyc("run0", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3000, 0, 0, 0);
        cyc("run1", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3004, 1, 0, 0);
        cyc("run2", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3008, 2, 0, 0);

        // Branch taken (0x3010 + 4 - 8 = 0x300C), then not taken, then j.
        cyc("br_taken", 0, NPC_BRANCH, 1, 32'h3010, 26'h000FFFE, 32'h0,
            32'h300C, 3, 1'(1 - DS), 0);
        cyc("br_nt", 0, NPC_BRANCH, 0, 32'h3010, 26'h000FFFE, 32'h0,
            32'h300C, 3 + DS, 0, 0);
        cyc("jump", 0, NPC_JUMP, 0, 32'h3010, 26'h0000C40, 32'h0,
            32'h3010, 4 + DS, 1'(1 - DS), 0);
        cyc("seq_j", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h3100, 4 + 2 * DS, 0, 0);

        // jr held by stall for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            cyc("jr_stall", 1, NPC_JR, 0, 32'h0, 26'h0, 32'h3100,
                32'h3104, 5 + 2 * DS, 0, 0);
        end
        cyc("jr_go", 0, NPC_JR, 0, 32'h0, 26'h0, 32'h3100,
            32'h3104, 5 + 2 * DS, 1'(1 - DS), 0);
        cyc("after_jr", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h3100, 5 + 3 * DS, 0, 0);

        // Async reset while a branch is pending in D.
        set_in(1'b0, NPC_BRANCH, 1'b1, 32'h3104, 26'h0000010, 32'h0);
        push_exp("pre_rst", 32'h3104, 6 + 3 * DS, 1'(1 - DS), 1'b0);
        do_reset("rst1");
        cyc("boot2", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3000, 0, 1, 0);
        cyc("rerun", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3000, 0, 0, 0);

        // jr to a misaligned address: error flag, then HALT with frozen PC.
        cyc("jr_bad", 0, NPC_JR, 0, 32'h0, 26'h0, 32'h3002, 32'h3004, 1, 1'(1 - DS), 0);
        cyc("misalign", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h3002, 1 + DS, 1, 1);
        cyc("halt0", 0, NPC_JUMP, 0, 32'h0, 26'h0000C40, 32'h0, 32'h3002, 1 + DS, 1, 1);
        cyc("halt1", 1, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h3002, 1 + DS, 1, 1);
        cyc("halt2", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h3002, 1 + DS, 1, 1);

        // Upper IM boundary: last word is valid, one past it halts.
        do_reset("rst2");
        cyc("boot3", 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h3000, 0, 1, 0);
        cyc("jr_top", 0, NPC_JR, 0, 32'h0, 26'h0, 32'h6FFC, 32'h3000, 0, 1'(1 - DS), 0);
        cyc("top_word", 0, NPC_JR, 0, 32'h0, 26'h0, 32'h7000, 32'h6FFC, DS, 1'(1 - DS), 0);
        cyc("past_top", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h7000, 2 * DS, 1, 1);
        cyc("halt_oor", 0, NPC_SEQ, 0, 32'h0, 26'h0, 32'h0, 32'h7000, 2 * DS, 1, 1);

        repeat (3) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
